// File: rtl/ysyx_22041071_ifu_pkg.sv
// Shared types and helpers for the AXI instruction-fetch unit.
// The optional line buffer is enabled by defining YSYX_22041071_IFU_LINEBUF_EN.
package ysyx_22041071_ifu_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ADDR  = 2'd1;
    localparam state_t ST_DATA  = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // AXI arsize encoding for a full-width beat: log2(bytes per beat).
    function automatic logic [2:0] size_enc(input int unsigned data_w);
        return 3'($clog2(data_w / 8));
    endfunction

    // Width of the lane selector; kept at least 1 so the port stays declarable.
    function automatic int unsigned lane_idx_w(input int unsigned data_w, input int unsigned ins_w);
        return (data_w > ins_w) ? $clog2(data_w / ins_w) : 1;
    endfunction

endpackage

// File: rtl/ysyx_22041071_ifu_linebuf.sv
// One-entry fetch line buffer: holds the last OKAY beat and serves lanes from it
// while the PC stays inside that line (used under YSYX_22041071_IFU_LINEBUF_EN).
module ysyx_22041071_ifu_linebuf
    import ysyx_22041071_ifu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int INS_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_tag,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              clear,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              hit,
    output logic [INS_W-1:0]  lane
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int IDX_W = lane_idx_w(DATA_W, INS_W);

    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  lane_idx;

    if (DATA_W > INS_W) begin : g_idx
        assign lane_idx = lookup_pc[OFF_W-1:OFF_W-IDX_W];
    end else begin : g_idx_single
        assign lane_idx = '0;
    end

    assign hit = vld_q && (tag_q == {lookup_pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}});

    always_comb begin
        vld_d  = vld_q;
        tag_d  = tag_q;
        data_d = data_q;
        if (clear) begin
            vld_d = 1'b0;
        end else if (fill_en) begin
            vld_d  = 1'b1;
            tag_d  = fill_tag;
            data_d = fill_data;
        end
        lane = data_q[INS_W-1:0];
        for (int i = 0; i < DATA_W / INS_W; i++) begin
            if (lane_idx == IDX_W'(i)) lane = data_q[i*INS_W +: INS_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) vld_q <= 1'b0;
        else       vld_q <= vld_d;
    end

    // NOTE: tag and data are qualified by vld_q, so they are deliberately left out of reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/ysyx_22041071_ifu_axi.sv
// Instruction-fetch unit: single-beat AXI reads, lane extraction, redirect squashing.
// Define YSYX_22041071_IFU_LINEBUF_EN to add a one-entry line buffer.
module ysyx_22041071_ifu_axi
    import ysyx_22041071_ifu_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                DATA_W   = 64,
    parameter int                INS_W    = 32,
    parameter int                LEN_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INS_W-1:0]  out_ins,
    output logic              out_err,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [LEN_W-1:0]  ar_len,
    output logic [2:0]        ar_size,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [DATA_W-1:0] r_data,
    input  logic [1:0]        r_resp,
    input  logic              r_last
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int IDX_W = lane_idx_w(DATA_W, INS_W);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic              squash_q, squash_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [INS_W-1:0]  out_ins_q, out_ins_d;
    logic              out_err_q, out_err_d;

    logic              slot_free, beat, beat_err;
    logic [ADDR_W-1:0] pc_aligned, pc_seq, redirect_aligned;
    logic [IDX_W-1:0]  lane_idx;
    logic [INS_W-1:0]  r_lane, lb_lane;
    logic              lb_hit;
    logic              unused_ok;

    assign slot_free        = !out_valid_q || out_ready;
    assign pc_aligned       = {pc_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign pc_seq           = pc_q + ADDR_W'(4);
    assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};

    assign ar_valid = (state_q == ST_ADDR);
    assign ar_addr  = ar_addr_q;
    assign ar_len   = '0;
    assign ar_size  = size_enc(DATA_W);
    assign r_ready  = (state_q == ST_DATA) ? slot_free : (state_q == ST_DRAIN);
    assign beat     = r_valid && r_ready;
    assign beat_err = (r_resp != RESP_OKAY);

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_ins   = out_ins_q;
    assign out_err   = out_err_q;

    assign unused_ok = ^{redirect_pc[1:0], r_last, inv};

    if (DATA_W > INS_W) begin : g_idx
        assign lane_idx = pc_q[OFF_W-1:OFF_W-IDX_W];
    end else begin : g_idx_single
        assign lane_idx = '0;
    end

    always_comb begin
        r_lane = r_data[INS_W-1:0];
        for (int i = 0; i < DATA_W / INS_W; i++) begin
            if (lane_idx == IDX_W'(i)) r_lane = r_data[i*INS_W +: INS_W];
        end
    end

`ifdef YSYX_22041071_IFU_LINEBUF_EN
    logic lb_fill, lb_clear, lb_match;

    // Only beats that actually reach decode may fill or clear the buffer.
    assign lb_fill  = (state_q == ST_DATA) && beat && !redirect_valid && !beat_err;
    assign lb_clear = inv || ((state_q == ST_DATA) && beat && !redirect_valid && beat_err);
    assign lb_hit   = lb_match && !inv;

    ysyx_22041071_ifu_linebuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .INS_W  (INS_W)
    ) u_linebuf (
        .clk       (clk),
        .reset     (reset),
        .fill_en   (lb_fill),
        .fill_tag  (ar_addr_q),
        .fill_data (r_data),
        .clear     (lb_clear),
        .lookup_pc (pc_q),
        .hit       (lb_match),
        .lane      (lb_lane)
    );
`else
    assign lb_hit  = 1'b0;
    assign lb_lane = '0;
`endif

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        ar_addr_d   = ar_addr_q;
        squash_d    = squash_q;
        out_valid_d = out_valid_q && !out_ready;
        out_pc_d    = out_pc_q;
        out_ins_d   = out_ins_q;
        out_err_d   = out_err_q;

        case (state_q)
            ST_IDLE: begin
                if (!redirect_valid && slot_free) begin
                    if (lb_hit) begin
                        out_valid_d = 1'b1;
                        out_pc_d    = pc_q;
                        out_ins_d   = lb_lane;
                        out_err_d   = 1'b0;
                        pc_d        = pc_seq;
                    end else begin
                        state_d   = ST_ADDR;
                        ar_addr_d = pc_aligned;
                    end
                end
            end
            ST_ADDR: begin
                // The address cannot be withdrawn, so a redirect here is remembered until the handshake.
                if (ar_valid && ar_ready) begin
                    state_d  = (squash_q || redirect_valid) ? ST_DRAIN : ST_DATA;
                    squash_d = 1'b0;
                end else if (redirect_valid) begin
                    squash_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (beat) begin
                    state_d = ST_IDLE;
                    if (!redirect_valid) begin
                        out_valid_d = 1'b1;
                        out_pc_d    = pc_q;
                        out_ins_d   = beat_err ? '0 : r_lane;
                        out_err_d   = beat_err;
                        pc_d        = pc_seq;
                    end
                end else if (redirect_valid) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (redirect_valid) begin
            pc_d        = redirect_aligned;
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state is only ever assigned with <= so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            ar_addr_q   <= '0;
            squash_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_ins_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ar_addr_q   <= ar_addr_d;
            squash_q    <= squash_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_ins_q   <= out_ins_d;
            out_err_q   <= out_err_d;
        end
    end

endmodule
